// File: rtl/fcmp_pipe.sv
// Two-stage binary32 compare / min-max / classify unit with valid-ready handshake and sticky NV.
// Define FCMP_MINMAX_EN to build FMIN/FMAX; otherwise ops 3/4 return out_err like reserved ops.
module fcmp_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_nv,
    output logic             out_err,
    input  logic             flags_clr,
    output logic             nv_sticky
);
    localparam logic [2:0] OP_FEQ    = 3'd0;
    localparam logic [2:0] OP_FLT    = 3'd1;
    localparam logic [2:0] OP_FLE    = 3'd2;
    localparam logic [2:0] OP_FCLASS = 3'd5;
`ifdef FCMP_MINMAX_EN
    localparam logic [2:0] OP_FMIN   = 3'd3;
    localparam logic [2:0] OP_FMAX   = 3'd4;
    localparam logic [WIDTH-1:0] CANON_NAN = 32'h7FC0_0000;
`endif

    // One-hot class: -inf,-norm,-sub,-0,+0,+sub,+norm,+inf,sNaN,qNaN (bit 0 first)
    function automatic logic [9:0] fclass(input logic [WIDTH-1:0] v);
        logic [9:0] c;
        c = '0;
        if (v[30:23] == 8'hFF) begin
            if (v[22:0] == 23'd0) c = v[31] ? 10'h001 : 10'h080;
            else if (v[22])       c = 10'h200;
            else                  c = 10'h100;
        end else if (v[30:23] == 8'h00) begin
            if (v[22:0] == 23'd0) c = v[31] ? 10'h008 : 10'h010;
            else                  c = v[31] ? 10'h004 : 10'h020;
        end else begin
            c = v[31] ? 10'h002 : 10'h040;
        end
        return c;
    endfunction

    // Sign-magnitude ordering that treats -0 as below +0; callers mask the zero case where needed
    function automatic logic lt_raw(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (a[31] != b[31]) return a[31];
        else if (a[31])     return a[30:0] > b[30:0];
        else                return a[30:0] < b[30:0];
    endfunction

    logic             vld_p1, vld_p2;
    logic [2:0]       op_p1;
    logic [WIDTH-1:0] a_p1, b_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [9:0]       cls_a_p1;
    logic             b_nan_p1, b_snan_p1, b_zero_p1;
    logic             adv_p1, adv_p2;

    assign adv_p2    = !vld_p2 || out_ready;
    assign adv_p1    = !vld_p1 || adv_p2;
    assign in_ready  = adv_p1;
    assign out_valid = vld_p2;

    // ---- stage 1: capture op, operands and class of both operands
    always_ff @(posedge clk) begin
        if (rst || flush) vld_p1 <= 1'b0;
        else if (adv_p1)  vld_p1 <= in_valid;
        if (adv_p1 && in_valid) begin
            op_p1     <= in_op;
            a_p1      <= in_a;
            b_p1      <= in_b;
            tag_p1    <= in_tag;
            cls_a_p1  <= fclass(in_a);
            b_nan_p1  <= (&in_b[30:23]) && (|in_b[22:0]);
            b_snan_p1 <= (&in_b[30:23]) && (|in_b[22:0]) && !in_b[22];
            b_zero_p1 <= (in_b[30:0] == 31'd0);
        end
    end

    logic             a_nan, any_nan, any_snan, both_zero, lt, eq;
    logic [WIDTH-1:0] res_data;
    logic             res_nv, res_err;

    always_comb begin
        a_nan     = cls_a_p1[9] || cls_a_p1[8];
        any_nan   = a_nan || b_nan_p1;
        any_snan  = cls_a_p1[8] || b_snan_p1;
        both_zero = (cls_a_p1[3] || cls_a_p1[4]) && b_zero_p1;
        lt        = lt_raw(a_p1, b_p1);
        eq        = (a_p1 == b_p1) || both_zero;
        res_data  = '0;
        res_nv    = 1'b0;
        res_err   = 1'b0;
        case (op_p1)
            OP_FEQ: begin
                res_data[0] = !any_nan && eq;
                res_nv      = any_snan;
            end
            OP_FLT: begin
                res_data[0] = !any_nan && lt && !both_zero;
                res_nv      = any_nan;
            end
            OP_FLE: begin
                res_data[0] = !any_nan && (lt || eq);
                res_nv      = any_nan;
            end
`ifdef FCMP_MINMAX_EN
            OP_FMIN, OP_FMAX: begin
                res_nv = any_snan;
                if (a_nan && b_nan_p1)              res_data = CANON_NAN;
                else if (a_nan)                     res_data = b_p1;
                else if (b_nan_p1)                  res_data = a_p1;
                else if (lt ^ (op_p1 == OP_FMAX))   res_data = a_p1;
                else                                res_data = b_p1;
            end
`endif
            OP_FCLASS: res_data[9:0] = cls_a_p1;
            default:   res_err = 1'b1;
        endcase
    end

    // ---- stage 2: result register, held while writeback stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
            out_nv   <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            if (flush)       vld_p2 <= 1'b0;
            else if (adv_p2) vld_p2 <= vld_p1;
            if (adv_p2 && vld_p1) begin
                out_data <= res_data;
                out_tag  <= tag_p1;
                out_nv   <= res_nv;
                out_err  <= res_err;
            end
        end
    end

    // Set beats a concurrent clear so an NV retiring during an fcsr write is not lost
    always_ff @(posedge clk) begin
        if (rst)                                 nv_sticky <= 1'b0;
        else if (out_valid && out_ready && out_nv) nv_sticky <= 1'b1;
        else if (flags_clr)                      nv_sticky <= 1'b0;
    end
endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe: vector table through a scoreboard plus stall/flush/reset sequences.
module tb_fcmp_pipe;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, flags_clr;
    logic        in_ready, out_valid, out_nv, out_err, nv_sticky;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b, out_data;
    logic [4:0]  in_tag, out_tag;

    always #5 clk = ~clk;

    fcmp_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_nv(out_nv), .out_err(out_err), .flags_clr(flags_clr), .nv_sticky(nv_sticky)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        nv;
        logic        err;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, d;
        logic        nv, err;
    } vec_t;

    exp_t sb[$];
    exp_t cur_exp;
    vec_t vt[$];
    int   n_chk = 0, n_pass = 0;
    logic [4:0] tag_ctr = 5'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Handshakes are evaluated on the falling edge, where inputs and outputs are stable
    always @(negedge clk) begin
        exp_t e;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_output: got tag %0d data %h, required no output", out_tag, out_data);
                end else begin
                    e = sb.pop_front();
                    if ({out_data, out_tag, out_nv, out_err} === e) n_pass++;
                    else $display("FAIL result tag %0d: got data=%h tag=%0d nv=%b err=%b, required data=%h tag=%0d nv=%b err=%b",
                                  e.tag, out_data, out_tag, out_nv, out_err, e.data, e.tag, e.nv, e.err);
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic nv, input logic err);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag_ctr;
        cur_exp  = '{data: d, tag: tag_ctr, nv: nv, err: err};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            n_chk++;
            $display("FAIL issue_timeout tag %0d: got in_ready=0, required 1 within 50 cycles", tag_ctr);
        end
        in_valid = 1'b0;
        tag_ctr++;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic add(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic nv, input logic err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.d = d; v.nv = nv; v.err = err;
        vt.push_back(v);
    endtask

    task automatic add_mm(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] d, input logic nv);
`ifdef FCMP_MINMAX_EN
        add(op, a, b, d, nv, 1'b0);
`else
        add(op, a, b, 32'd0, 1'b0, 1'b1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
        in_op = 3'd0; in_a = '0; in_b = '0; in_tag = '0;
        cur_exp = '0;

        add(3'd2, 32'h3F800000, 32'h40000000, 32'd1, 1'b0, 1'b0);
        add(3'd2, 32'h7FC00000, 32'h3F800000, 32'd0, 1'b1, 1'b0);
        add(3'd0, 32'h00000000, 32'h80000000, 32'd1, 1'b0, 1'b0);
        add(3'd0, 32'h7F800001, 32'h00000000, 32'd0, 1'b1, 1'b0);
        add(3'd0, 32'h7FC00000, 32'h7FC00000, 32'd0, 1'b0, 1'b0);
        add(3'd1, 32'h40000000, 32'h3F800000, 32'd0, 1'b0, 1'b0);
        add(3'd1, 32'hBF800000, 32'h3F800000, 32'd1, 1'b0, 1'b0);
        add(3'd1, 32'hC0000000, 32'hBF800000, 32'd1, 1'b0, 1'b0);
        add(3'd1, 32'h80000000, 32'h00000000, 32'd0, 1'b0, 1'b0);
        add(3'd1, 32'h3F800000, 32'h7FC00000, 32'd0, 1'b1, 1'b0);
        add(3'd2, 32'h3F800000, 32'h3F800000, 32'd1, 1'b0, 1'b0);
        add_mm(3'd3, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0);
        add_mm(3'd4, 32'h7FC00000, 32'h7F800001, 32'h7FC00000, 1'b1);
        add_mm(3'd4, 32'h3F800000, 32'h7FC00000, 32'h3F800000, 1'b0);
        add_mm(3'd3, 32'h40000000, 32'hC0000000, 32'hC0000000, 1'b0);
        add_mm(3'd4, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
        add(3'd5, 32'hFF800000, 32'h0, 32'h001, 1'b0, 1'b0);
        add(3'd5, 32'h00000001, 32'h0, 32'h020, 1'b0, 1'b0);
        add(3'd5, 32'h7F800001, 32'h0, 32'h100, 1'b0, 1'b0);
        add(3'd5, 32'h7FC00000, 32'h0, 32'h200, 1'b0, 1'b0);
        add(3'd5, 32'h3F800000, 32'h0, 32'h040, 1'b0, 1'b0);
        add(3'd5, 32'h80000000, 32'h0, 32'h008, 1'b0, 1'b0);
        add(3'd7, 32'h3F800000, 32'h3F800000, 32'd0, 1'b0, 1'b1);
        add(3'd6, 32'h7F800001, 32'h00000000, 32'd0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_nv_err", 64'({out_nv, out_err}), 64'd0);
        chk("rst_nv_sticky", 64'(nv_sticky), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // Full-throughput table run
        foreach (vt[i]) issue(vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].nv, vt[i].err);
        drain("table_drain");
        chk("sticky_set", 64'(nv_sticky), 64'd1);
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        chk("sticky_clr", 64'(nv_sticky), 64'd0);

        // Latency and clear-vs-set collision
        issue(3'd1, 32'h7FC00000, 32'h00000000, 32'd0, 1'b1, 1'b0);
        chk("latency_c1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("latency_c2", 64'(out_valid), 64'd1);
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        chk("sticky_set_wins", 64'(nv_sticky), 64'd1);
        drain("collide_drain");

        // Backpressure: four ops with writeback stalled
        out_ready = 1'b0;
        issue(3'd0, 32'h3F800000, 32'h3F800000, 32'd1, 1'b0, 1'b0);
        issue(3'd1, 32'h3F800000, 32'h40000000, 32'd1, 1'b0, 1'b0);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        fork
            begin
                issue(3'd2, 32'h40000000, 32'h3F800000, 32'd0, 1'b0, 1'b0);
                issue(3'd5, 32'hBF800000, 32'h0, 32'h002, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("stall_hold", 64'({out_valid, in_ready}), 64'b10);
                out_ready = 1'b1;
            end
        join
        drain("stall_drain");

        // Flush with two ops in flight plus one presented during the flush cycle
        out_ready = 1'b0;
        issue(3'd0, 32'h0, 32'h0, 32'd1, 1'b0, 1'b0);
        issue(3'd5, 32'h0, 32'h0, 32'h010, 1'b0, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'd1;
        in_tag   = tag_ctr;
        cur_exp  = '{data: 32'd0, tag: tag_ctr, nv: 1'b0, err: 1'b0};
        tag_ctr++;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_kill", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        issue(3'd2, 32'hBF800000, 32'h80000000, 32'd1, 1'b0, 1'b0);
        chk("flush_next_c1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("flush_next_c2", 64'({out_valid, out_tag}), 64'({1'b1, 5'(tag_ctr - 5'd1)}));
        drain("flush_drain");
        repeat (4) @(posedge clk);
        #1;
        chk("flush_no_ghost", 64'(out_valid), 64'd0);

        // Reset with ops in flight
        out_ready = 1'b0;
        issue(3'd0, 32'h3F800000, 32'h3F800000, 32'd1, 1'b0, 1'b0);
        issue(3'd0, 32'h7F800001, 32'h3F800000, 32'd0, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_quiet", 64'({out_valid, nv_sticky}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
